// File: rtl/sound_clip_scheduler.sv
// Sound clip scheduler: latches request pulses from the game logic, grants
// clips by fixed priority (clip 0 highest) and walks the shared clip ROM,
// handing one sample per SAMPLE_DIV cycles to the Audio_Controller.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing playing, grant the lowest pending clip
// FETCH | rom_addr stable, waiting ROM_LATENCY cycles for rom_q
// PUSH  | rom_q valid, waiting for FIFO space, then strobe the sample
// PACE  | spacing out samples; preemption is decided on exit
module sound_clip_scheduler #(
    parameter int                  ADDR_W      = 18,
    parameter int                  DATA_W      = 6,
    parameter int                  SAMPLE_DIV  = 1200,
    parameter int                  ROM_LATENCY = 2,
    parameter logic [4*ADDR_W-1:0] CLIP_START  = {18'd83255, 18'd66983, 18'd16396, 18'd0},
    parameter logic [4*ADDR_W-1:0] CLIP_END    = {18'd137138, 18'd83254, 18'd66982, 18'd16395},
    parameter logic [3:0]          LOOP_MASK   = 4'b0000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic              stop,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              audio_out_allowed,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       audio_sample,
    output logic              write_audio_out,
    output logic              busy,
    output logic [1:0]        active_clip,
    output logic              clip_done
);

    // ROM_LATENCY is expected to be at least 1; FETCH then lasts exactly that long.
    localparam int CNT_W = $clog2(SAMPLE_DIV + 1);
    localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(ROM_LATENCY - 1);
    localparam logic [CNT_W-1:0] PACE_LOAD  = CNT_W'(SAMPLE_DIV - 2 - ROM_LATENCY);

    typedef enum logic [1:0] {IDLE, FETCH, PUSH, PACE} state_t;

    state_t           state;
    logic [3:0]       pending;
    logic [CNT_W-1:0] cnt;

    logic             pend_any;
    logic [1:0]       pend_idx;
    logic [3:0]       grant_mask;
    logic             preempt;
    logic [ADDR_W-1:0] grant_start;
    logic [ADDR_W-1:0] cur_start;
    logic [ADDR_W-1:0] cur_end;
    logic             cur_loop;

    // Lowest pending index and the table entries of the grant and current clip.
    always_comb begin
        pend_any = |pending;
        pend_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) pend_idx = 2'(i);
        end
        grant_mask  = 4'b0001 << pend_idx;
        preempt     = pend_any && (pend_idx < active_clip);
        grant_start = CLIP_START[pend_idx*ADDR_W +: ADDR_W];
        cur_start   = CLIP_START[active_clip*ADDR_W +: ADDR_W];
        cur_end     = CLIP_END[active_clip*ADDR_W +: ADDR_W];
        cur_loop    = LOOP_MASK[active_clip];
    end

    // Request latching, grant/preempt sequencing and sample pacing.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            pending         <= '0;
            cnt             <= '0;
            rom_addr        <= '0;
            audio_sample    <= '0;
            write_audio_out <= 1'b0;
            busy            <= 1'b0;
            active_clip     <= 2'd0;
            clip_done       <= 1'b0;
        end else begin
            write_audio_out <= 1'b0;
            clip_done       <= 1'b0;
            if (stop) begin
                // Requests arriving together with stop are dropped as well.
                state   <= IDLE;
                pending <= '0;
                busy    <= 1'b0;
            end else begin
                pending <= pending | req;
                case (state)
                    IDLE: begin
                        if (pend_any) begin
                            active_clip <= pend_idx;
                            rom_addr    <= grant_start;
                            pending     <= (pending & ~grant_mask) | req;
                            cnt         <= FETCH_LOAD;
                            busy        <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (cnt == '0) state <= PUSH;
                        else           cnt   <= cnt - 1'b1;
                    end
                    PUSH: begin
                        if (audio_out_allowed) begin
                            write_audio_out <= 1'b1;
                            audio_sample    <= {rom_q, {(32-DATA_W){1'b0}}};
                            if (rom_addr != cur_end) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                cnt      <= PACE_LOAD;
                                state    <= PACE;
                            end else if (cur_loop) begin
                                rom_addr <= cur_start;
                                cnt      <= PACE_LOAD;
                                state    <= PACE;
                            end else begin
                                clip_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    PACE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (preempt) begin
                            // Higher-priority clip takes over; the dropped one gets no clip_done.
                            active_clip <= pend_idx;
                            rom_addr    <= grant_start;
                            pending     <= (pending & ~grant_mask) | req;
                            cnt         <= FETCH_LOAD;
                            state       <= FETCH;
                        end else begin
                            cnt   <= FETCH_LOAD;
                            state <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_clip_scheduler.sv
// Bench for sound_clip_scheduler: directed scenarios with hand-derived cycle
// numbers, then random request traffic checked against an event-time model.
module tb_sound_clip_scheduler;

    localparam int SD = 8;
    localparam int L  = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0;
    logic        stop = 1'b0;
    logic [5:0]  rom_q;
    logic        audio_out_allowed = 1'b1;
    logic [17:0] rom_addr;
    logic [31:0] audio_sample;
    logic        write_audio_out;
    logic        busy;
    logic [1:0]  active_clip;
    logic        clip_done;

    int tests_run = 0;
    int tests_failed = 0;

    int cs[4] = '{20, 10, 0, 40};
    int ce[4] = '{20, 13, 2, 43};
    bit lp[4] = '{0, 0, 1, 0};

    sound_clip_scheduler #(
        .ADDR_W(18), .DATA_W(6), .SAMPLE_DIV(SD), .ROM_LATENCY(L),
        .CLIP_START({18'd40, 18'd0, 18'd10, 18'd20}),
        .CLIP_END({18'd43, 18'd2, 18'd13, 18'd20}),
        .LOOP_MASK(4'b0100)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .stop(stop),
        .rom_q(rom_q), .audio_out_allowed(audio_out_allowed),
        .rom_addr(rom_addr), .audio_sample(audio_sample),
        .write_audio_out(write_audio_out), .busy(busy),
        .active_clip(active_clip), .clip_done(clip_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [5:0] rom_f(input int a);
        int t;
        t = a * 13 + 5;
        return t[5:0];
    endfunction

    // Clip ROM with two cycles of address-to-data latency.
    logic [17:0] a1, a2;
    always @(posedge CLOCK_50) begin
        a1 <= rom_addr;
        a2 <= a1;
    end
    assign rom_q = rom_f(int'(a2));

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; req = 4'b0; stop = 1'b0; audio_out_allowed = 1'b1;
        tick(); tick();
        tests_run += 6;
        if (rom_addr !== 18'd0) begin tests_failed++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        if (audio_sample !== 32'd0) begin tests_failed++; $display("FAIL reset_sample got %h want 0", audio_sample); end
        if (write_audio_out !== 1'b0) begin tests_failed++; $display("FAIL reset_write got %b want 0", write_audio_out); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        if (active_clip !== 2'd0) begin tests_failed++; $display("FAIL reset_active got %0d want 0", active_clip); end
        if (clip_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", clip_done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ew;
        req = 4'b0010; tick(); req = 4'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            ew = (e == 4 || e == 12 || e == 20 || e == 28);
            tests_run += 2;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL single_write e=%0d got %b want %b", e, write_audio_out, ew); end
            if (clip_done !== (e == 28)) begin tests_failed++; $display("FAIL single_done e=%0d got %b", e, clip_done); end
            if (ew) begin
                tests_run++;
                if (audio_sample !== {rom_f(10 + (e - 4) / 8), 26'b0}) begin tests_failed++; $display("FAIL single_sample e=%0d got %h want %h", e, audio_sample, {rom_f(10 + (e - 4) / 8), 26'b0}); end
            end
            if (e == 1) begin
                tests_run += 3;
                if (active_clip !== 2'd1) begin tests_failed++; $display("FAIL single_active got %0d want 1", active_clip); end
                if (rom_addr !== 18'd10) begin tests_failed++; $display("FAIL single_addr got %0d want 10", rom_addr); end
                if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_hi got %b want 1", busy); end
            end
            if (e == 29) begin
                tests_run++;
                if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_lo got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_priority();
        bit ew;
        int a;
        req = 4'b1010; tick(); req = 4'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            ew = 0; a = 0;
            if (e >= 4 && e <= 28 && (e - 4) % 8 == 0) begin ew = 1; a = 10 + (e - 4) / 8; end
            if (e >= 32 && e <= 56 && (e - 32) % 8 == 0) begin ew = 1; a = 40 + (e - 32) / 8; end
            tests_run += 2;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL prio_write e=%0d got %b want %b", e, write_audio_out, ew); end
            if (clip_done !== (e == 28 || e == 56)) begin tests_failed++; $display("FAIL prio_done e=%0d got %b", e, clip_done); end
            if (ew) begin
                tests_run++;
                if (audio_sample !== {rom_f(a), 26'b0}) begin tests_failed++; $display("FAIL prio_sample e=%0d got %h want %h", e, audio_sample, {rom_f(a), 26'b0}); end
            end
            if (e == 1 || e == 29) begin
                tests_run += 2;
                if (active_clip !== ((e == 1) ? 2'd1 : 2'd3)) begin tests_failed++; $display("FAIL prio_active e=%0d got %0d", e, active_clip); end
                if (rom_addr !== ((e == 1) ? 18'd10 : 18'd40)) begin tests_failed++; $display("FAIL prio_addr e=%0d got %0d", e, rom_addr); end
            end
        end
    endtask

    task automatic test_preempt();
        bit ew;
        req = 4'b1000; tick(); req = 4'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            ew = (e == 4 || e == 12);
            tests_run += 2;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL preempt_write e=%0d got %b want %b", e, write_audio_out, ew); end
            if (clip_done !== (e == 12)) begin tests_failed++; $display("FAIL preempt_done e=%0d got %b", e, clip_done); end
            if (ew) begin
                tests_run++;
                if (audio_sample !== {rom_f((e == 4) ? 40 : 20), 26'b0}) begin tests_failed++; $display("FAIL preempt_sample e=%0d got %h", e, audio_sample); end
            end
            if (e == 8 || e == 9) begin
                tests_run++;
                if (active_clip !== ((e == 8) ? 2'd3 : 2'd0)) begin tests_failed++; $display("FAIL preempt_active e=%0d got %0d", e, active_clip); end
            end
            if (e == 9) begin
                tests_run++;
                if (rom_addr !== 18'd20) begin tests_failed++; $display("FAIL preempt_addr got %0d want 20", rom_addr); end
            end
            if (e == 13) begin
                tests_run++;
                if (busy !== 1'b0) begin tests_failed++; $display("FAIL preempt_busy got %b want 0", busy); end
            end
            req = (e == 5) ? 4'b0001 : 4'b0000;
        end
    endtask

    task automatic test_backpressure();
        bit ew;
        audio_out_allowed = 1'b0;
        req = 4'b0010; tick(); req = 4'b0;
        for (int e = 1; e <= 50; e++) begin
            tick();
            ew = (e >= 24 && (e - 24) % 8 == 0 && e <= 48);
            tests_run += 2;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL bp_write e=%0d got %b want %b", e, write_audio_out, ew); end
            if (clip_done !== (e == 48)) begin tests_failed++; $display("FAIL bp_done e=%0d got %b", e, clip_done); end
            if (ew) begin
                tests_run++;
                if (audio_sample !== {rom_f(10 + (e - 24) / 8), 26'b0}) begin tests_failed++; $display("FAIL bp_sample e=%0d got %h", e, audio_sample); end
            end
            if (e <= 23) begin
                tests_run++;
                if (rom_addr !== 18'd10) begin tests_failed++; $display("FAIL bp_addr e=%0d got %0d want 10", e, rom_addr); end
            end
            if (e == 23) audio_out_allowed = 1'b1;
        end
    endtask

    task automatic test_loop_stop();
        bit ew;
        req = 4'b0100; tick(); req = 4'b0;
        for (int e = 1; e <= 70; e++) begin
            tick();
            ew = (e >= 4 && e <= 36 && (e - 4) % 8 == 0);
            tests_run += 2;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL loop_write e=%0d got %b want %b", e, write_audio_out, ew); end
            if (clip_done !== 1'b0) begin tests_failed++; $display("FAIL loop_done e=%0d got %b want 0", e, clip_done); end
            if (ew) begin
                tests_run++;
                if (audio_sample !== {rom_f(((e - 4) / 8) % 3), 26'b0}) begin tests_failed++; $display("FAIL loop_sample e=%0d got %h want %h", e, audio_sample, {rom_f(((e - 4) / 8) % 3), 26'b0}); end
            end
            if (e >= 37) begin
                tests_run++;
                if (busy !== (e == 37)) begin tests_failed++; $display("FAIL stop_busy e=%0d got %b", e, busy); end
            end
            stop = (e == 37);
            req = (e == 37) ? 4'b0010 : 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        bit ew;
        req = 4'b1000; tick(); req = 4'b0001; tick(); req = 4'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        tests_run += 6;
        if (rom_addr !== 18'd0) begin tests_failed++; $display("FAIL rstmid_addr got %0d want 0", rom_addr); end
        if (audio_sample !== 32'd0) begin tests_failed++; $display("FAIL rstmid_sample got %h want 0", audio_sample); end
        if (write_audio_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_write got %b want 0", write_audio_out); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (active_clip !== 2'd0) begin tests_failed++; $display("FAIL rstmid_active got %0d want 0", active_clip); end
        if (clip_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done got %b want 0", clip_done); end
        for (int e = 0; e < 30; e++) begin
            tick();
            tests_run++;
            if (busy !== 1'b0 || write_audio_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_quiet e=%0d busy=%b write=%b want 0 0", e, busy, write_audio_out); end
        end
        req = 4'b0010; tick(); req = 4'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            ew = (e == 4 || e == 12 || e == 20 || e == 28);
            tests_run++;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL rstmid_replay e=%0d got %b want %b", e, write_audio_out, ew); end
        end
    endtask

    task automatic test_random();
        logic [3:0] m_pend, r;
        logic [31:0] es;
        bit m_play, ew, ed, drained;
        int m_clip, m_j, nxt_s, nxt_d, g;
        m_pend = 4'b0; m_play = 0; m_clip = 0; m_j = 0; nxt_s = -1; nxt_d = -1; drained = 0;
        for (int n = 0; n < 800; n++) begin
            r = 4'b0;
            if (n < 450 && $urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15)) & 4'b1011;
            req = r; tick(); req = 4'b0;
            ew = 0; ed = 0; es = '0; g = -1;
            if (!m_play) begin
                if (m_pend != 0) g = lowest(m_pend);
            end else if (n == nxt_s) begin
                ew = 1; es = {rom_f(cs[m_clip] + m_j), 26'b0}; nxt_s = -1;
                if (m_j == ce[m_clip] - cs[m_clip]) begin
                    if (lp[m_clip]) begin m_j = 0; nxt_d = n + SD - 1 - L; end
                    else begin ed = 1; m_play = 0; end
                end else begin
                    m_j++; nxt_d = n + SD - 1 - L;
                end
            end else if (n == nxt_d) begin
                nxt_d = -1;
                if (m_pend != 0 && lowest(m_pend) < m_clip) g = lowest(m_pend);
                else nxt_s = n + L + 1;
            end
            if (g >= 0) begin
                m_play = 1; m_clip = g; m_j = 0; nxt_s = n + L + 1; nxt_d = -1; m_pend[g] = 1'b0;
            end
            m_pend = m_pend | r;
            tests_run += 3;
            if (write_audio_out !== ew) begin tests_failed++; $display("FAIL rand_write n=%0d got %b want %b", n, write_audio_out, ew); end
            if (clip_done !== ed) begin tests_failed++; $display("FAIL rand_done n=%0d got %b want %b", n, clip_done, ed); end
            if (busy !== m_play) begin tests_failed++; $display("FAIL rand_busy n=%0d got %b want %b", n, busy, m_play); end
            if (ew) begin
                tests_run++;
                if (audio_sample !== es) begin tests_failed++; $display("FAIL rand_sample n=%0d got %h want %h", n, audio_sample, es); end
            end
            if (g >= 0) begin
                tests_run += 2;
                if (active_clip !== 2'(g)) begin tests_failed++; $display("FAIL rand_active n=%0d got %0d want %0d", n, active_clip, g); end
                if (rom_addr !== 18'(cs[g])) begin tests_failed++; $display("FAIL rand_addr n=%0d got %0d want %0d", n, rom_addr, cs[g]); end
            end
            if (n >= 450 && !m_play && m_pend == 4'b0) begin drained = 1; break; end
        end
        tests_run++;
        if (!drained) begin tests_failed++; $display("FAIL rand_drain got busy=%b want idle within budget", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_backpressure();
        test_loop_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
